// File: rtl/reg_e_to_m_pkg.sv
// Shared CPU package: opcode/funct constants and T_new helpers used by the
// pipeline registers and the hazard unit.
package reg_e_to_m_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  // No register result is ever produced by an instruction tagged with this.
  localparam logic [4:0] T_NEW_NONE = 5'h1F;

  // One stage elapses per capture; "ready now" and "no result" do not age.
  function automatic logic [4:0] age_t_new(input logic [4:0] t_new);
    if (t_new == 5'd0 || t_new == T_NEW_NONE) return t_new;
    return t_new - 5'd1;
  endfunction

  // jal and jalr write the link address instead of the ALU result.
  function automatic logic is_link(input logic [31:0] instr);
    return (instr[31:26] == OP_JAL) ||
           (instr[31:26] == OP_RTYPE && instr[5:0] == FUNCT_JALR);
  endfunction

endpackage

// File: rtl/reg_e_to_m_dest_decode.sv
// Destination register decode from the instruction word (combinational).
module dest_decode
  import reg_e_to_m_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  a3
);

  always_comb begin
    a3 = 5'd0;
    unique case (instr[31:26])
      OP_RTYPE: begin
        if (instr != 32'd0 && instr[5:0] != FUNCT_JR) a3 = instr[15:11];
      end
      OP_JAL: a3 = 5'd31;
      OP_ORI, OP_XORI, OP_ANDI, OP_SLTI, OP_SLTIU, OP_ADDI, OP_ADDIU,
      OP_LUI, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: a3 = instr[20:16];
      default: a3 = 5'd0;
    endcase
  end

endmodule

// File: rtl/reg_e_to_m.sv
// E-to-M pipeline register with T_new aging and forwarding outputs.
// Define REG_E_TO_M_DEST_DECODE_EN to derive A3 from Instr_in instead of A3_in.
module reg_e_to_m
  import reg_e_to_m_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] Instr_in,
  input  logic [31:0] PC_plus_8_in,
  input  logic [4:0]  A3_in,
  input  logic [4:0]  T_new_in,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ReadData2_in,
  output logic [31:0] Instruction,
  output logic [31:0] PC_plus_8,
  output logic [4:0]  A3,
  output logic [4:0]  T_new,
  output logic [31:0] ALU_out,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [31:0] FwdData,
  output logic        FwdValid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  a3_q, a3_d;
  logic [4:0]  t_new_q, t_new_d;

  logic [4:0]  dest_a3;
  logic [4:0]  t_new_aged;

`ifdef REG_E_TO_M_DEST_DECODE_EN
  logic unused_a3_in;
  assign unused_a3_in = ^A3_in;

  dest_decode u_dest_decode (
    .instr (Instr_in),
    .a3    (dest_a3)
  );
`else
  assign dest_a3 = A3_in;
`endif

  assign t_new_aged = age_t_new(T_new_in);

  always_comb begin
    instr_d = instr_q;
    pc8_d   = pc8_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    a3_d    = a3_q;
    t_new_d = t_new_q;
    if (flush) begin
      instr_d = 32'd0;
      pc8_d   = 32'd0;
      alu_d   = 32'd0;
      wdata_d = 32'd0;
      a3_d    = 5'd0;
      t_new_d = T_NEW_NONE;
    end else if (en) begin
      instr_d = Instr_in;
      pc8_d   = PC_plus_8_in;
      alu_d   = ALU_result;
      wdata_d = ReadData2_in;
      t_new_d = t_new_aged;
      // A result-less instruction must never look like a register writer.
      a3_d    = (t_new_aged == T_NEW_NONE) ? 5'd0 : dest_a3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'd0;
      pc8_q   <= 32'd0;
      alu_q   <= 32'd0;
      wdata_q <= 32'd0;
      a3_q    <= 5'd0;
      t_new_q <= 5'd0;
    end else begin
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      a3_q    <= a3_d;
      t_new_q <= t_new_d;
    end
  end

  assign Instruction = instr_q;
  assign PC_plus_8   = pc8_q;
  assign A3          = a3_q;
  assign T_new       = t_new_q;
  assign ALU_out     = alu_q;
  assign WriteData   = wdata_q;
  assign RegWrite    = (a3_q != 5'd0);
  assign FwdData     = is_link(instr_q) ? pc8_q : alu_q;
  assign FwdValid    = (t_new_q == 5'd0) && (a3_q != 5'd0);

endmodule

// File: tb/tb_reg_e_to_m.sv
// Directed and randomized bench for reg_e_to_m against a behavioural model.
// Honours REG_E_TO_M_DEST_DECODE_EN the same way the design does.
module tb_reg_e_to_m;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] Instr_in;
  logic [31:0] PC_plus_8_in;
  logic [4:0]  A3_in;
  logic [4:0]  T_new_in;
  logic [31:0] ALU_result;
  logic [31:0] ReadData2_in;
  logic [31:0] Instruction;
  logic [31:0] PC_plus_8;
  logic [4:0]  A3;
  logic [4:0]  T_new;
  logic [31:0] ALU_out;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] FwdData;
  logic        FwdValid;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the stored stage state
  logic [31:0] m_instr, m_pc8, m_alu, m_wdata;
  logic [4:0]  m_a3, m_tnew;

  always #5 clk = ~clk;

  reg_e_to_m dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .Instr_in     (Instr_in),
    .PC_plus_8_in (PC_plus_8_in),
    .A3_in        (A3_in),
    .T_new_in     (T_new_in),
    .ALU_result   (ALU_result),
    .ReadData2_in (ReadData2_in),
    .Instruction  (Instruction),
    .PC_plus_8    (PC_plus_8),
    .A3           (A3),
    .T_new        (T_new),
    .ALU_out      (ALU_out),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .FwdData      (FwdData),
    .FwdValid     (FwdValid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [4:0] model_dest(input logic [31:0] ins, input logic [4:0] a3_in);
`ifdef REG_E_TO_M_DEST_DECODE_EN
    int op = int'(ins[31:26]);
    if (op == 0) return (ins != 0 && ins[5:0] != 6'h08) ? ins[15:11] : 5'd0;
    if (op == 3) return 5'd31;
    if ((op >= 8 && op <= 15) || op == 32 || op == 33 || op == 35 || op == 36 || op == 37)
      return ins[20:16];
    return 5'd0;
`else
    return a3_in;
`endif
  endfunction

  task automatic model_reset();
    m_instr = 0; m_pc8 = 0; m_alu = 0; m_wdata = 0; m_a3 = 0; m_tnew = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_instr = 0; m_pc8 = 0; m_alu = 0; m_wdata = 0; m_a3 = 0; m_tnew = 5'd31;
    end else if (en) begin
      m_instr = Instr_in;
      m_pc8   = PC_plus_8_in;
      m_alu   = ALU_result;
      m_wdata = ReadData2_in;
      m_tnew  = (T_new_in == 0 || T_new_in == 31) ? T_new_in : T_new_in - 5'd1;
      m_a3    = (m_tnew == 31) ? 5'd0 : model_dest(Instr_in, A3_in);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic link;
    link = (m_instr[31:26] == 6'd3) || (m_instr[31:26] == 6'd0 && m_instr[5:0] == 6'd9);
    check({ctx, ".Instruction"}, Instruction, m_instr);
    check({ctx, ".PC_plus_8"},   PC_plus_8,   m_pc8);
    check({ctx, ".A3"},          32'(A3),     32'(m_a3));
    check({ctx, ".T_new"},       32'(T_new),  32'(m_tnew));
    check({ctx, ".ALU_out"},     ALU_out,     m_alu);
    check({ctx, ".WriteData"},   WriteData,   m_wdata);
    check({ctx, ".RegWrite"},    32'(RegWrite), 32'(m_a3 != 0));
    check({ctx, ".FwdData"},     FwdData,     link ? m_pc8 : m_alu);
    check({ctx, ".FwdValid"},    32'(FwdValid), 32'(m_tnew == 0 && m_a3 != 0));
  endtask

  task automatic cycle(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    $display("%s en=%b flush=%b instr=%h A3=%0d T_new=%0d FwdValid=%b FwdData=%h",
             ctx, en, flush, Instr_in, A3, T_new, FwdValid, FwdData);
    check_outputs(ctx);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [4:0] a3, input logic [4:0] tn,
                       input logic [31:0] pc8, input logic [31:0] alu, input logic [31:0] rd2);
    Instr_in = ins; A3_in = a3; T_new_in = tn;
    PC_plus_8_in = pc8; ALU_result = alu; ReadData2_in = rd2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [20];
    logic [5:0] functs [4];
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h03, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B};
    functs = '{6'h21, 6'h08, 6'h09, 6'h2A};
    ins = $urandom;
    if ($urandom_range(0, 9) == 0) return 32'd0;
    if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 19)];
    if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = functs[$urandom_range(0, 3)];
    return ins;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    drive(32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // addiu $5: T_new 1 ages to 0, forwardable now
    en = 1'b1;
    drive(32'h24050007, 5'd5, 5'd1, 32'h1008, 32'd7, 32'h0);
    cycle("addiu");
    check("addiu.A3_const", 32'(A3), 32'd5);
    check("addiu.FwdValid_const", 32'(FwdValid), 32'd1);

    // lw $8: still one stage away, so not forwardable
    drive(32'h8C080000, 5'd8, 5'd2, 32'h100C, 32'h2000, 32'h0);
    cycle("lw");
    check("lw.T_new_const", 32'(T_new), 32'd1);
    check("lw.FwdValid_const", 32'(FwdValid), 32'd0);

    // jal: forwards the link address
    drive(32'h0C000010, 5'd31, 5'd0, 32'h3008, 32'h5555, 32'h0);
    cycle("jal");
    check("jal.FwdData_const", FwdData, 32'h3008);

    // sw: no destination, store data passes through
    drive(32'hAC090004, 5'd9, 5'h1F, 32'h3010, 32'h4, 32'hDEADBEEF);
    cycle("sw");
    check("sw.RegWrite_const", 32'(RegWrite), 32'd0);
    check("sw.WriteData_const", WriteData, 32'hDEADBEEF);

    // addu $4,$5,$6 then stall three cycles with changing inputs
    drive(32'h00A62021, 5'd4, 5'd1, 32'h3014, 32'h11, 32'h22);
    cycle("addu");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(), 5'($urandom), 5'd2, $urandom, $urandom, $urandom);
      cycle("stall");
    end
    check("stall.Instruction_const", Instruction, 32'h00A62021);

    // flush with en=0 still loads a bubble
    flush = 1'b1;
    cycle("flush");
    check("flush.T_new_const", 32'(T_new), 32'h1F);
    flush = 1'b0;

    // reload addu, stall, then reset pulse between edges
    en = 1'b1;
    drive(32'h00A62021, 5'd4, 5'd1, 32'h3018, 32'h33, 32'h44);
    cycle("addu2");
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    #1;
    reset = 1'b0;
    en = 1'b1;
    drive(32'h24050007, 5'd5, 5'd1, 32'h1008, 32'd7, 32'h0);
    cycle("post_reset");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [4:0] tn;
      logic [31:0] ins;
      ins = rand_instr();
      case ($urandom_range(0, 4))
        0: tn = 5'd0;
        1: tn = 5'd1;
        2: tn = 5'd2;
        3: tn = 5'h1F;
        default: tn = 5'($urandom);
      endcase
      en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(ins, 5'($urandom), tn, $urandom, $urandom, $urandom);
      cycle($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_e_to_m.md
REG_E_TO_M -- requirements
Module: reg_e_to_m

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have inputs: en 1 (capture enable; low = stall hold), flush 1 (insert bubble), Instr_in 32, PC_plus_8_in 32, A3_in 5 (rd field from E stage), T_new_in 5, ALU_result 32, ReadData2_in 32 (forwarded rt value, store data).
REQ-003 SHALL have outputs: Instruction 32, PC_plus_8 32, A3 5, T_new 5, ALU_out 32, WriteData 32, RegWrite 1, FwdData 32, FwdValid 1.
REQ-004 SHALL use T_new encoding: 5-bit unsigned cycles-until-result; 5'h1F = instruction produces no register result.

Function
REQ-005 SHALL capture all stage state on the rising clk edge when en=1 and flush=0; SHALL hold every register when en=0 and flush=0.
REQ-006 SHALL age T_new on capture: T_new_in in {0, 5'h1F} -> stored unchanged; otherwise T_new_in-1 (one stage elapsed).
REQ-007 SHALL, with DEST_DECODE_EN defined, decode destination A3 from Instr_in[31:26]: 000000 (nonzero instruction, funct != jr 001000) -> Instr_in[15:11]; 000011 (jal) -> 5'd31; ori/xori/andi/slti/sltiu/addi/addiu/lui/lw/lb/lbu/lh/lhu -> Instr_in[20:16]; all else (stores, branches, j, jr, nop, unknown) -> 0.
REQ-008 SHALL force stored A3 to 0 whenever stored T_new would be 5'h1F.
REQ-009 SHALL drive RegWrite = (A3 != 0), combinationally from registered state.
REQ-010 SHALL drive FwdData = PC_plus_8 when stored instruction is jal or jalr (opcode 000000, funct 001001), else ALU_out.
REQ-011 SHALL drive FwdValid = (T_new == 0) && (A3 != 0); data from loads (T_new 1 after aging) is never flagged valid.
REQ-012 SHALL, on flush=1 at a clock edge, load a bubble regardless of en: all data registers 0, A3 0, T_new 5'h1F.
REQ-013 SHALL prioritise reset > flush > en.
REQ-014 SHALL pass WriteData = captured ReadData2_in unmodified (store data path).

Reset
REQ-015 SHALL, while reset=1, asynchronously clear Instruction, PC_plus_8, ALU_out, WriteData, A3 and T_new to 0; RegWrite and FwdValid therefore read 0.
REQ-016 SHALL resume normal capture on the first rising edge after reset deasserts; reset asserted mid-stall discards held state.

Configuration
REQ-017 SHALL support macro REG_E_TO_M_DEST_DECODE_EN: defined -> REQ-007 decode active, A3_in ignored; undefined -> stored A3 = A3_in (still subject to REQ-008), decode logic absent.

Structure
REQ-018 SHALL place opcode/funct constants and T_NEW_NONE (5'h1F) in the shared CPU package used by the D-to-E register and hazard unit.
REQ-019 SHALL implement destination decode as sub-module dest_decode (pure combinational, instantiated only under REG_E_TO_M_DEST_DECODE_EN).
REQ-020 SHALL keep all state in a single clocked process; output logic combinational from state only.

Verification
REQ-021 addiu $5 (0x24050007), T_new_in=1, ALU_result=7, en=1 -> next edge: A3=5, T_new=0, FwdValid=1, FwdData=7.
REQ-022 lw $8 (0x8C080000), T_new_in=2 -> A3=8, T_new=1, FwdValid=0, RegWrite=1.
REQ-023 jal (0x0C000010), T_new_in=0, PC_plus_8_in=0x3008 -> A3=31, T_new=0, FwdData=0x3008, FwdValid=1.
REQ-024 sw (0xAC090004), T_new_in=5'h1F, ReadData2_in=0xDEADBEEF -> A3=0, RegWrite=0, WriteData=0xDEADBEEF.
REQ-025 en=0 for 3 cycles with changing inputs -> outputs frozen; flush=1 with en=0 -> bubble (T_new=5'h1F, A3=0) next edge.
REQ-026 reset pulse between clock edges while holding addu state -> all outputs 0 immediately, no edge required.
